// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with programmable divider, glitch filter and receive FIFO
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DIV_W-1:0]     cfg_divider,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]           cfg_parity,
`endif
  input  logic                 ser_rx,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_nxt;

  logic                 rx_m, rx_s, rx_d;
  logic                 start_edge;
  logic [DIV_W-1:0]     div_q, cnt;
  logic                 cnt_wrap, cnt_mid;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic                 load, cnt_clr, shift, push_req, stop_ok;

  // rx_d is one cycle behind the synchronised line and only feeds edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= ser_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;
  assign cnt_wrap   = (cnt == div_q - DIV_W'(1));
  assign cnt_mid    = (cnt == (div_q >> 1));

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_odd_q, par_acc, par_bad_q, par_sample;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc   <= 1'b0;
      par_bad_q <= 1'b0;
    end else if (load) begin
      par_en_q  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_odd_q <= (cfg_parity == 2'b10);
      par_acc   <= 1'b0;
      par_bad_q <= 1'b0;
    end else if (shift) begin
      par_acc <= par_acc ^ rx_s;
    end else if (par_sample) begin
      par_bad_q <= (par_acc ^ rx_s) != par_odd_q;
    end
  end

  assign stop_ok = rx_s & ~par_bad_q;
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_clr   = 1'b0;
    shift     = 1'b0;
    push_req  = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        // Re-check mid start bit; a high line here is a glitch, not a frame
        if (cnt_mid) begin
          if (!rx_s) begin
            cnt_clr   = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          shift = 1'b1;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = par_en_q ? PARITY : STOP;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_wrap) begin
          par_sample = 1'b1;
          state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_wrap) begin
          state_nxt = IDLE;
          if (stop_ok) push_req  = 1'b1;
          else         frame_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= DIV_MIN;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      if (load) begin
        div_q   <= (cfg_divider < DIV_MIN) ? DIV_MIN : cfg_divider;
        cnt     <= '0;
        bit_idx <= '0;
      end else if (cnt_clr || cnt_wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (shift) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 full, pop, push;

  assign rd_valid   = (wptr != rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = rd_valid & rd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept
  assign push       = push_req & (~full | pop);
  assign overrun    = push_req & full & ~pop;
  assign rd_data    = rd_valid ? mem[rptr[AW-1:0]] : '0;
  assign fifo_level = LVL_W'(wptr - rptr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

endmodule
